// File: rtl/alu_pkg.sv
// Shared definitions for the multi-cycle ALU.
//   op_e      : operation codes carried on alu_op
//   state_e   : control FSM states
//   iter_mode : selects the iterative datapath function
package alu_pkg;

  typedef enum logic [2:0] {
    OP_NOP  = 3'd0,
    OP_CMPU = 3'd1,
    OP_ZERO = 3'd2,
    OP_ADD  = 3'd3,
    OP_SUB  = 3'd4,
    OP_CMPS = 3'd5,
    OP_MUL  = 3'd6,
    OP_DIVU = 3'd7
  } op_e;

  typedef enum logic [1:0] {
    S_IDLE = 2'd0,
    S_RUN  = 2'd1,
    S_DONE = 2'd2
  } state_e;

  // Value carried on the alu_iter mode port.
  localparam logic ITER_MUL = 1'b0;
  localparam logic ITER_DIV = 1'b1;

endpackage

// File: rtl/alu_iter.sv
// Shared shift-register datapath for shift-add multiply and restoring divide.
// Ports:
//   clk, rst : clock, asynchronous active-high reset
//   load     : capture operands and clear the accumulator
//   step     : perform one iteration
//   mode     : ITER_MUL or ITER_DIV, captured on load
//   a, b     : operands (multiplicand/multiplier or dividend/divisor)
//   hi, lo   : accumulator value after the current step
//              (MUL: product high/low, DIV: remainder/quotient)
module alu_iter
  import alu_pkg::*;
#(
  parameter int WIDTH = 32
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             load,
  input  logic             step,
  input  logic             mode,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  output logic [WIDTH-1:0] hi,
  output logic [WIDTH-1:0] lo
);

  logic             mode_q;
  logic [WIDTH-1:0] acc_hi;
  logic [WIDTH-1:0] acc_lo;
  logic [WIDTH-1:0] opd;

  logic [WIDTH:0]   sum;
  logic [WIDTH:0]   shifted;
  logic [WIDTH-1:0] rem_try;
  logic             fits;

  // hi/lo present the post-step value so the top can register the final
  // result on the same edge as the last iteration.
  always_comb begin
    sum     = {1'b0, acc_hi} + {1'b0, opd};
    shifted = {acc_hi, acc_lo[WIDTH-1]};
    fits    = (shifted >= {1'b0, opd});
    // When fits, the true difference is below opd, so modular WIDTH-bit
    // subtraction is exact.
    rem_try = shifted[WIDTH-1:0] - opd;
    hi      = acc_hi;
    lo      = acc_lo;
    if (mode_q == ITER_MUL) begin
      if (acc_lo[0]) begin
        {hi, lo} = {sum, acc_lo[WIDTH-1:1]};
      end else begin
        {hi, lo} = {1'b0, acc_hi, acc_lo[WIDTH-1:1]};
      end
    end else begin
      if (fits) begin
        hi = rem_try;
        lo = {acc_lo[WIDTH-2:0], 1'b1};
      end else begin
        hi = shifted[WIDTH-1:0];
        lo = {acc_lo[WIDTH-2:0], 1'b0};
      end
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      mode_q <= ITER_MUL;
      acc_hi <= '0;
      acc_lo <= '0;
      opd    <= '0;
    end else if (load) begin
      mode_q <= mode;
      acc_hi <= '0;
      if (mode == ITER_DIV) begin
        acc_lo <= a;
        opd    <= b;
      end else begin
        acc_lo <= b;
        opd    <= a;
      end
    end else if (step) begin
      acc_hi <= hi;
      acc_lo <= lo;
    end
  end

endmodule

// File: rtl/alu_mc.sv
// Multi-cycle ALU with start/busy/done handshake.
// Ports:
//   clk, rst      : clock, asynchronous active-high reset
//   start         : request, accepted when busy=0
//   alu_op        : operation code (op_e), sampled with start
//   in0, in1      : operands A and B, sampled with start
//   out0          : sum / difference / product low / quotient
//   out1          : product high / remainder, else 0
//   zero, bigger  : equality-zero flag, A>=B flag (compares)
//   overflow      : signed overflow, product overflow, divide by zero
//   busy          : high while MUL/DIVU iterate
//   done          : one-cycle pulse when results update
module alu_mc
  import alu_pkg::*;
#(
  parameter int WIDTH = 32,
  parameter int CNT_W = $clog2(WIDTH) + 1
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             start,
  input  logic [2:0]       alu_op,
  input  logic [WIDTH-1:0] in0,
  input  logic [WIDTH-1:0] in1,
  output logic [WIDTH-1:0] out0,
  output logic [WIDTH-1:0] out1,
  output logic             zero,
  output logic             bigger,
  output logic             overflow,
  output logic             busy,
  output logic             done
);

  state_e           state;
  logic [CNT_W-1:0] cnt;
  logic             run_div;

  op_e              op;
  logic [WIDTH-1:0] sum;
  logic [WIDTH-1:0] dif;
  logic [WIDTH-1:0] sc_out0;
  logic [WIDTH-1:0] sc_out1;
  logic             sc_zero;
  logic             sc_bigger;
  logic             sc_ovf;
  logic             sc_iter;

  logic             iter_load;
  logic             iter_step;
  logic [WIDTH-1:0] iter_hi;
  logic [WIDTH-1:0] iter_lo;

  logic             accept;

  assign accept    = start && (state != S_RUN);
  assign iter_load = accept && sc_iter;
  assign iter_step = (state == S_RUN);

  alu_iter #(
    .WIDTH(WIDTH)
  ) u_iter (
    .clk  (clk),
    .rst  (rst),
    .load (iter_load),
    .step (iter_step),
    .mode ((op == OP_DIVU) ? ITER_DIV : ITER_MUL),
    .a    (in0),
    .b    (in1),
    .hi   (iter_hi),
    .lo   (iter_lo)
  );

  // Single-cycle results, plus the decision whether the op must iterate.
  always_comb begin
    op        = op_e'(alu_op);
    sum       = in0 + in1;
    dif       = in0 - in1;
    sc_out0   = '0;
    sc_out1   = '0;
    sc_zero   = 1'b0;
    sc_bigger = 1'b0;
    sc_ovf    = 1'b0;
    sc_iter   = 1'b0;
    case (op)
      OP_NOP: ;
      OP_CMPU: begin
        sc_zero   = (in0 == in1);
        sc_bigger = (in0 >= in1);
      end
      OP_ZERO: sc_zero = 1'b1;
      OP_ADD: begin
        sc_out0 = sum;
        sc_zero = (sum == '0);
        sc_ovf  = (in0[WIDTH-1] == in1[WIDTH-1]) && (sum[WIDTH-1] != in0[WIDTH-1]);
      end
      OP_SUB: begin
        sc_out0 = dif;
        sc_zero = (dif == '0);
        sc_ovf  = (in0[WIDTH-1] != in1[WIDTH-1]) && (dif[WIDTH-1] != in0[WIDTH-1]);
      end
      OP_CMPS: begin
        sc_zero   = (in0 == in1);
        sc_bigger = ($signed(in0) >= $signed(in1));
      end
      OP_MUL: sc_iter = 1'b1;
      OP_DIVU: begin
        if (in1 == '0) begin
          sc_out0 = '1;
          sc_out1 = in0;
          sc_ovf  = 1'b1;
        end else begin
          sc_iter = 1'b1;
        end
      end
      default: ;
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state    <= S_IDLE;
      cnt      <= '0;
      run_div  <= 1'b0;
      out0     <= '0;
      out1     <= '0;
      zero     <= 1'b0;
      bigger   <= 1'b0;
      overflow <= 1'b0;
      busy     <= 1'b0;
      done     <= 1'b0;
    end else begin
      done <= 1'b0;
      case (state)
        S_IDLE, S_DONE: begin
          state <= S_IDLE;
          if (start) begin
            if (sc_iter) begin
              state   <= S_RUN;
              busy    <= 1'b1;
              cnt     <= CNT_W'(WIDTH);
              run_div <= (op == OP_DIVU);
            end else begin
              state    <= S_DONE;
              done     <= 1'b1;
              out0     <= sc_out0;
              out1     <= sc_out1;
              zero     <= sc_zero;
              bigger   <= sc_bigger;
              overflow <= sc_ovf;
            end
          end
        end
        S_RUN: begin
          cnt <= cnt - CNT_W'(1);
          if (cnt == CNT_W'(1)) begin
            state    <= S_DONE;
            busy     <= 1'b0;
            done     <= 1'b1;
            out1     <= iter_hi;
            out0     <= iter_lo;
            bigger   <= 1'b0;
            if (run_div) begin
              zero     <= (iter_lo == '0);
              overflow <= 1'b0;
            end else begin
              zero     <= (iter_hi == '0) && (iter_lo == '0);
              overflow <= (iter_hi != '0);
            end
          end
        end
        default: state <= S_IDLE;
      endcase
    end
  end

endmodule
